// File: rtl/instr_issue.sv
// Instruction sequencer: host loads a program into a small instruction RAM, then start
// steps a PC through it and offers each word to the datapath on a valid/ready port.
module instr_issue #(
   parameter int AW    = 4,
   parameter int DEPTH = 1 << AW,
   parameter int IW    = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          prog_we,
   input  logic [AW-1:0] prog_addr,
   input  logic [IW-1:0] prog_data,
   input  logic          start,
   input  logic [AW:0]   prog_len,
   output logic [IW-1:0] ir,
   output logic          ir_valid,
   input  logic          ir_ready,
   output logic [AW-1:0] pc,
   output logic          busy,
   output logic          done,
   output logic          err
);

   localparam logic [1:0]  S_IDLE  = 2'd0;
   localparam logic [1:0]  S_FETCH = 2'd1;
   localparam logic [1:0]  S_ISSUE = 2'd2;
   localparam logic [1:0]  S_FIN   = 2'd3;
   localparam logic [4:0]  OP_MAX  = 5'b01011;
   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE_W   = (AW+1)'(1);

   logic [IW-1:0] r_mem [DEPTH];
   logic [1:0]    r_state;
   logic [1:0]    w_next;
   logic [AW:0]   r_len;
   logic [AW-1:0] r_pc;
   logic [IW-1:0] r_ir;
   logic          r_ir_valid;
   logic          r_busy;
   logic          r_done;
   logic          r_err;

   logic [IW-1:0] w_rd_word;
   logic          w_bad_op;
   logic          w_hs;
   logic          w_last;
   logic [AW:0]   w_len_clip;

   assign w_rd_word  = r_mem[r_pc];
   assign w_bad_op   = (w_rd_word[31:27] > OP_MAX);
   assign w_hs       = r_ir_valid & ir_ready;
   assign w_last     = ({1'b0, r_pc} == (r_len - ONE_W));
   assign w_len_clip = (prog_len > DEPTH_W) ? DEPTH_W : prog_len;

   // Instruction RAM: writable only while idle, contents survive reset.
   always_ff @(posedge clk) begin
      if ((r_state == S_IDLE) && prog_we) begin
         r_mem[prog_addr] <= prog_data;
      end
   end

   // Next-state selection for the sequencer.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_next = (w_len_clip == '0) ? S_FIN : S_FETCH;
            end else begin
               w_next = S_IDLE;
            end
         end
         S_FETCH: begin
            if (w_bad_op) begin
               w_next = S_FIN;
            end else begin
               w_next = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (w_hs) begin
               w_next = w_last ? S_FIN : S_FETCH;
            end else begin
               w_next = S_ISSUE;
            end
         end
         S_FIN:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Sequencer state, PC, instruction register and status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_len      <= '0;
         r_pc       <= '0;
         r_ir       <= '0;
         r_ir_valid <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_state <= w_next;
         r_busy  <= (w_next == S_FETCH) || (w_next == S_ISSUE);
         // done is the registered image of FIN, so it pulses as the block returns to idle
         r_done  <= (r_state == S_FIN);
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_len <= w_len_clip;
                  r_err <= 1'b0;
                  r_pc  <= '0;
               end
            end
            S_FETCH: begin
               r_ir <= w_rd_word;
               if (w_bad_op) begin
                  r_err <= 1'b1;
               end else begin
                  r_ir_valid <= 1'b1;
               end
            end
            S_ISSUE: begin
               if (w_hs) begin
                  r_ir_valid <= 1'b0;
                  if (!w_last) begin
                     r_pc <= r_pc + {{(AW-1){1'b0}}, 1'b1};
                  end
               end
            end
            S_FIN: begin
               r_ir_valid <= 1'b0;
            end
            default: begin
               r_ir_valid <= 1'b0;
            end
         endcase
      end
   end

   assign ir       = r_ir;
   assign ir_valid = r_ir_valid;
   assign pc       = r_pc;
   assign busy     = r_busy;
   assign done     = r_done;
   assign err      = r_err;

endmodule

// File: tb/tb_instr_issue.sv
// Randomized bench for instr_issue: a program-level model predicts the issued word
// sequence, error flag and done timing for each run.
module tb_instr_issue;

   localparam int AW    = 4;
   localparam int DEPTH = 16;
   localparam int IW    = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          prog_we;
   logic [AW-1:0] prog_addr;
   logic [IW-1:0] prog_data;
   logic          start;
   logic [AW:0]   prog_len;
   logic [IW-1:0] ir;
   logic          ir_valid;
   logic          ir_ready;
   logic [AW-1:0] pc;
   logic          busy;
   logic          done;
   logic          err;

   int            n_checks = 0;
   int            n_errors = 0;
   logic [31:0]   model_mem [DEPTH];

   always #5 clk = ~clk;

   instr_issue #(.AW(AW), .DEPTH(DEPTH), .IW(IW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .prog_we   (prog_we),
      .prog_addr (prog_addr),
      .prog_data (prog_data),
      .start     (start),
      .prog_len  (prog_len),
      .ir        (ir),
      .ir_valid  (ir_valid),
      .ir_ready  (ir_ready),
      .pc        (pc),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] make_word(input bit allow_bad);
      logic [31:0] w;
      w = $urandom;
      if (allow_bad && ($urandom_range(0, 3) == 0)) begin
         w[31:27] = 5'($urandom_range(12, 31));
      end else begin
         w[31:27] = 5'($urandom_range(0, 11));
      end
      return w;
   endfunction

   task automatic load(input int addr, input logic [31:0] data);
      prog_we   = 1'b1;
      prog_addr = addr[AW-1:0];
      prog_data = data;
      tick;
      prog_we   = 1'b0;
      model_mem[addr] = data;
   endtask

   // ready_mode: 0 = always ready, 1 = random, 2 = stalled for the first cycles
   task automatic run(input int len, input int ready_mode, input bit noise,
                      input bit wr0, input logic [31:0] wr0_data,
                      output int first_valid_idx, output int done_idx);
      int          eff;
      int          exp_n;
      bit          exp_err;
      logic [31:0] exp_q [$];
      int          k;
      bit          prev_valid;
      bit          prev_ready;
      logic [31:0] prev_ir;
      logic [AW-1:0] prev_pc;
      bit          finished;

      exp_q.delete();
      if (wr0) begin
         prog_we   = 1'b1;
         prog_addr = '0;
         prog_data = wr0_data;
         model_mem[0] = wr0_data;
      end
      eff     = (len > DEPTH) ? DEPTH : len;
      exp_err = 1'b0;
      for (int i = 0; i < eff; i++) begin
         if (model_mem[i][31:27] > 5'd11) begin
            exp_err = 1'b1;
            break;
         end
         exp_q.push_back(model_mem[i]);
      end
      exp_n = exp_q.size();

      start    = 1'b1;
      prog_len = len[AW:0];
      tick;
      start    = 1'b0;
      prog_we  = 1'b0;

      first_valid_idx = -1;
      done_idx        = -1;
      k               = 0;
      prev_valid      = 1'b0;
      prev_ready      = 1'b0;
      prev_ir         = '0;
      prev_pc         = '0;
      finished        = 1'b0;
      for (int c = 0; c < 400 && !finished; c++) begin
         if (prev_valid && !prev_ready) begin
            check_eq("stall_valid", 32'(ir_valid), 32'd1);
            check_eq("stall_ir", ir, prev_ir);
            check_eq("stall_pc", 32'(pc), 32'(prev_pc));
         end
         if (ir_valid && (first_valid_idx < 0)) first_valid_idx = c;
         if (done) begin
            done_idx = c;
            finished = 1'b1;
            prog_we  = 1'b0;
            start    = 1'b0;
         end else begin
            case (ready_mode)
               0:       ir_ready = 1'b1;
               1:       ir_ready = 1'($urandom_range(0, 1));
               default: ir_ready = (c >= 6);
            endcase
            if (noise) begin
               prog_we   = 1'($urandom_range(0, 1));
               prog_addr = '0;
               prog_data = $urandom;
               start     = 1'($urandom_range(0, 1));
               prog_len  = 5'd1;
            end
            if (ir_valid && ir_ready) begin
               if (k < exp_n) begin
                  check_eq("issue_ir", ir, exp_q[k]);
                  check_eq("issue_pc", 32'(pc), 32'(k));
               end
               k++;
            end
            prev_valid = ir_valid;
            prev_ready = ir_ready;
            prev_ir    = ir;
            prev_pc    = pc;
            tick;
         end
      end
      check_eq("done_seen", 32'(finished), 32'd1);
      check_eq("hs_count", 32'(k), 32'(exp_n));
      check_eq("err_flag", 32'(err), 32'(exp_err));
      check_eq("valid_after_run", 32'(ir_valid), 32'd0);
      check_eq("busy_after_run", 32'(busy), 32'd0);
      ir_ready = 1'b0;
      tick;
      check_eq("done_width", 32'(done), 32'd0);
   endtask

   initial begin
      int fv;
      int di;
      rst_n     = 1'b0;
      prog_we   = 1'b0;
      prog_addr = '0;
      prog_data = '0;
      start     = 1'b0;
      prog_len  = '0;
      ir_ready  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_ir", ir, 32'd0);
      check_eq("rst_valid", 32'(ir_valid), 32'd0);
      check_eq("rst_pc", 32'(pc), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      check_eq("rst_err", 32'(err), 32'd0);
      rst_n = 1'b1;
      tick;

      for (int a = 0; a < DEPTH; a++) load(a, make_word(1'b0));

      // Two-word program, always ready
      load(0, 32'h08410005);
      load(1, 32'h10830003);
      run(2, 0, 1'b0, 1'b0, 32'd0, fv, di);
      check_eq("t1_first_valid", 32'(fv), 32'd1);
      check_eq("t1_done_cycle", 32'(di), 32'd5);

      // Same program with a five-cycle stall
      run(2, 2, 1'b0, 1'b0, 32'd0, fv, di);
      check_eq("t2_first_valid", 32'(fv), 32'd1);
      check_eq("t2_done_cycle", 32'(di), 32'd10);

      // Undefined opcode at word 1, then err cleared by the next start
      load(1, 32'h60000000);
      run(3, 0, 1'b0, 1'b0, 32'd0, fv, di);
      check_eq("t3_done_cycle", 32'(di), 32'd4);
      load(1, 32'h10830003);
      run(2, 0, 1'b0, 1'b0, 32'd0, fv, di);

      // Empty program and over-length program
      run(0, 0, 1'b0, 1'b0, 32'd0, fv, di);
      check_eq("t4_len0_done", 32'(di), 32'd1);
      check_eq("t4_len0_novalid", 32'(fv), 32'hFFFFFFFF);
      run(20, 1, 1'b0, 1'b0, 32'd0, fv, di);

      // Writes and starts while busy are ignored
      run(16, 1, 1'b1, 1'b0, 32'd0, fv, di);
      run(2, 0, 1'b0, 1'b0, 32'd0, fv, di);

      // Write to address 0 in the same cycle as start
      run(2, 0, 1'b0, 1'b1, make_word(1'b0), fv, di);

      // Asynchronous reset during ISSUE
      start    = 1'b1;
      prog_len = 5'd2;
      tick;
      start    = 1'b0;
      ir_ready = 1'b0;
      tick;
      check_eq("t6_valid_before_rst", 32'(ir_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("t6_rst_ir", ir, 32'd0);
      check_eq("t6_rst_valid", 32'(ir_valid), 32'd0);
      check_eq("t6_rst_pc", 32'(pc), 32'd0);
      check_eq("t6_rst_busy", 32'(busy), 32'd0);
      check_eq("t6_rst_done", 32'(done), 32'd0);
      #2 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick;
         check_eq("t6_no_done", 32'(done), 32'd0);
         check_eq("t6_idle_busy", 32'(busy), 32'd0);
      end
      run(2, 0, 1'b0, 1'b0, 32'd0, fv, di);

      // Random programs, lengths, back-pressure and busy-time noise
      for (int t = 0; t < 25; t++) begin
         int nw;
         nw = $urandom_range(0, 4);
         for (int j = 0; j < nw; j++) load($urandom_range(0, DEPTH - 1), make_word(1'b1));
         run($urandom_range(0, 20), 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             make_word(1'b1), fv, di);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
